// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo-N event counter family.
package counter_pkg;

  localparam int EDGE_FALL = 0;
  localparam int EDGE_RISE = 1;
  localparam int MODE_SAT  = 0;
  localparam int MODE_WRAP = 1;

  // Saturating clamp of a load value into the legal count range 0..modulus-1.
  function automatic logic [31:0] clamp_mod(input logic [31:0] value, input logic [31:0] modulus);
    return (value >= modulus) ? (modulus - 32'd1) : value;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Single-input clock-synchronous edge detector with selectable polarity.
module edge_detect
  import counter_pkg::*;
#(
  parameter int EDGE = EDGE_FALL
) (
  input  logic clk,
  input  logic Reset,
  input  logic din,
  output logic ev
);

  logic din_q, din_d;

  // Reset also loads the live input so a level held across release is not an edge.
  always_comb din_d = din;

  always_ff @(posedge clk) begin
    din_q <= din_d;
  end

  always_comb begin
    ev = 1'b0;
    if (!Reset) begin
      if (EDGE == EDGE_RISE) ev = ~din_q & din;
      else                   ev = din_q & ~din;
    end
  end

endmodule

// File: rtl/mod_n_event_counter.sv
// Up/down modulo-N event counter with load, wrap or saturate, and cascade pulses.
module mod_n_event_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10,
  parameter int WRAP    = MODE_WRAP,
  parameter int EDGE    = EDGE_FALL
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Add,
  input  logic             Sub,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_val,
  output logic [WIDTH-1:0] Cnt,
  output logic             Cnt_tc,
  output logic             Cnt_zero,
  output logic             Carry,
  output logic             Borrow
);

  if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_params
    $error("mod_n_event_counter: illegal WIDTH/MODULUS combination");
  end

  // Terminal count compared one bit wider so MODULUS == 2**WIDTH needs no special case.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic             up_ev, down_ev;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             at_top, at_zero;

  edge_detect #(.EDGE(EDGE)) u_add_edge (
    .clk   (clk),
    .Reset (Reset),
    .din   (Add),
    .ev    (up_ev)
  );

  edge_detect #(.EDGE(EDGE)) u_sub_edge (
    .clk   (clk),
    .Reset (Reset),
    .din   (Sub),
    .ev    (down_ev)
  );

  assign at_top  = ({1'b0, cnt_q} == MAX_EXT);
  assign at_zero = (cnt_q == '0);

  always_comb begin
    cnt_d    = cnt_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (Load) begin
      cnt_d = WIDTH'(clamp_mod(32'(Load_val), 32'(MODULUS)));
    end else if (up_ev && !down_ev) begin
      if (!at_top) begin
        cnt_d = cnt_q + 1'b1;
      end else if (WRAP == MODE_WRAP) begin
        cnt_d   = '0;
        carry_d = 1'b1;
      end
    end else if (down_ev && !up_ev) begin
      if (!at_zero) begin
        cnt_d = cnt_q - 1'b1;
      end else if (WRAP == MODE_WRAP) begin
        cnt_d    = MAX_CNT;
        borrow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign Cnt      = cnt_q;
  assign Cnt_tc   = at_top;
  assign Cnt_zero = at_zero;
  assign Carry    = carry_q;
  assign Borrow   = borrow_q;

endmodule

// File: tb/tb_mod_n_event_counter.sv
// Randomized and directed bench for mod_n_event_counter against a behavioural model.
module tb_mod_n_event_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       add[5], sub[5], ld[5];
  logic [3:0] lv[5];
  logic [3:0] cnt[5];
  logic [2:0] cnt2_w;
  logic       tc[5], zr[5], cy[5], bw[5];

  int checks = 0;
  int errors = 0;

  // 0: default decade, 1: saturating mod-6, 2: full-range mod-8 rising, 3/4: cascaded units/tens
  mod_n_event_counter u0 (
    .clk(clk), .Reset(rst), .Add(add[0]), .Sub(sub[0]), .Load(ld[0]), .Load_val(lv[0]),
    .Cnt(cnt[0]), .Cnt_tc(tc[0]), .Cnt_zero(zr[0]), .Carry(cy[0]), .Borrow(bw[0]));

  mod_n_event_counter #(.WIDTH(4), .MODULUS(6), .WRAP(0), .EDGE(0)) u1 (
    .clk(clk), .Reset(rst), .Add(add[1]), .Sub(sub[1]), .Load(ld[1]), .Load_val(lv[1]),
    .Cnt(cnt[1]), .Cnt_tc(tc[1]), .Cnt_zero(zr[1]), .Carry(cy[1]), .Borrow(bw[1]));

  mod_n_event_counter #(.WIDTH(3), .MODULUS(8), .WRAP(1), .EDGE(1)) u2 (
    .clk(clk), .Reset(rst), .Add(add[2]), .Sub(sub[2]), .Load(ld[2]), .Load_val(lv[2][2:0]),
    .Cnt(cnt2_w), .Cnt_tc(tc[2]), .Cnt_zero(zr[2]), .Carry(cy[2]), .Borrow(bw[2]));
  assign cnt[2] = {1'b0, cnt2_w};

  mod_n_event_counter #(.WIDTH(4), .MODULUS(10), .WRAP(1), .EDGE(1)) u_units (
    .clk(clk), .Reset(rst), .Add(add[3]), .Sub(sub[3]), .Load(ld[3]), .Load_val(lv[3]),
    .Cnt(cnt[3]), .Cnt_tc(tc[3]), .Cnt_zero(zr[3]), .Carry(cy[3]), .Borrow(bw[3]));

  mod_n_event_counter #(.WIDTH(4), .MODULUS(10), .WRAP(1), .EDGE(1)) u_tens (
    .clk(clk), .Reset(rst), .Add(cy[3]), .Sub(sub[4]), .Load(ld[4]), .Load_val(lv[4]),
    .Cnt(cnt[4]), .Cnt_tc(tc[4]), .Cnt_zero(zr[4]), .Carry(cy[4]), .Borrow(bw[4]));

  typedef struct {
    int cnt;
    bit carry;
    bit borrow;
    bit pa;
    bit ps;
  } st_t;

  int  mods[5]  = '{10, 6, 8, 10, 10};
  bit  wraps[5] = '{1, 0, 1, 1, 1};
  bit  edges[5] = '{0, 0, 1, 1, 1};
  st_t ms[5];
  bit  started = 1'b0;

  function automatic st_t step(st_t s, int m, bit wrap, bit edg, bit r, bit a, bit b, bit l, int v);
    st_t n;
    bit  up, dn;
    n        = s;
    n.pa     = a;
    n.ps     = b;
    n.carry  = 1'b0;
    n.borrow = 1'b0;
    up = edg ? (a && !s.pa) : (!a && s.pa);
    dn = edg ? (b && !s.ps) : (!b && s.ps);
    if (r) n.cnt = 0;
    else if (l) n.cnt = (v < m) ? v : m - 1;
    else if (up && !dn) begin
      if (s.cnt + 1 < m) n.cnt = s.cnt + 1;
      else if (wrap) begin n.cnt = 0; n.carry = 1'b1; end
    end else if (dn && !up) begin
      if (s.cnt > 0) n.cnt = s.cnt - 1;
      else if (wrap) begin n.cnt = m - 1; n.borrow = 1'b1; end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) ms[i] = '{0, 1'b0, 1'b0, 1'b0, 1'b0};
  end

  // Tens digit sees the units Carry as it stood before this edge.
  always @(posedge clk) begin : model
    bit units_cy;
    int v;
    units_cy = ms[3].carry;
    for (int i = 0; i < 5; i++) begin
      v = (i == 2) ? int'(lv[2][2:0]) : int'(lv[i]);
      ms[i] = step(ms[i], mods[i], wraps[i], edges[i], rst,
                   (i == 4) ? units_cy : add[i], sub[i], ld[i], v);
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("u%0d_cnt", i),    int'(cnt[i]), ms[i].cnt);
        chk($sformatf("u%0d_tc", i),     int'(tc[i]),  int'(ms[i].cnt == mods[i] - 1));
        chk($sformatf("u%0d_zero", i),   int'(zr[i]),  int'(ms[i].cnt == 0));
        chk($sformatf("u%0d_carry", i),  int'(cy[i]),  int'(ms[i].carry));
        chk($sformatf("u%0d_borrow", i), int'(bw[i]),  int'(ms[i].borrow));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      add[i] = 1'b0; sub[i] = 1'b0; ld[i] = 1'b0; lv[i] = 4'd0;
    end
    add[2] = 1'b1;
    repeat (3) tick();
    chk("reset_cnt", int'(cnt[0]), 0);
    chk("reset_zero", int'(zr[0]), 1);
    chk("reset_tc", int'(tc[0]), 0);
    rst = 1'b0;
    repeat (2) tick();
    chk("rise_held_through_reset", int'(cnt[2]), 0);

    for (int k = 1; k <= 10; k++) begin
      add[0] = 1'b1; tick();
      add[0] = 1'b0; tick();
      chk($sformatf("decade_cnt_%0d", k), int'(cnt[0]), k % 10);
      chk($sformatf("decade_tc_%0d", k), int'(tc[0]), int'(k == 9));
      chk($sformatf("decade_carry_%0d", k), int'(cy[0]), int'(k == 10));
    end
    tick();
    chk("carry_one_cycle", int'(cy[0]), 0);

    for (int k = 0; k < 8; k++) begin
      add[1] = 1'b1; tick(); add[1] = 1'b0; tick();
    end
    chk("sat_top", int'(cnt[1]), 5);
    chk("sat_top_carry", int'(cy[1]), 0);
    for (int k = 0; k < 7; k++) begin
      sub[1] = 1'b1; tick(); sub[1] = 1'b0; tick();
    end
    chk("sat_bottom", int'(cnt[1]), 0);
    chk("sat_bottom_borrow", int'(bw[1]), 0);

    ld[0] = 1'b1; lv[0] = 4'd12; tick(); ld[0] = 1'b0;
    chk("load_clamp", int'(cnt[0]), 9);
    add[0] = 1'b1; tick();
    ld[0] = 1'b1; lv[0] = 4'd3; add[0] = 1'b0; tick(); ld[0] = 1'b0;
    chk("load_beats_event", int'(cnt[0]), 3);

    ld[0] = 1'b1; lv[0] = 4'd4; tick(); ld[0] = 1'b0;
    add[0] = 1'b1; sub[0] = 1'b1; tick();
    add[0] = 1'b0; sub[0] = 1'b0; tick();
    chk("both_edges_hold", int'(cnt[0]), 4);

    ld[0] = 1'b1; lv[0] = 4'd0; tick(); ld[0] = 1'b0;
    sub[0] = 1'b1; tick(); sub[0] = 1'b0; tick();
    chk("borrow_wrap_cnt", int'(cnt[0]), 9);
    chk("borrow_pulse", int'(bw[0]), 1);
    tick();
    chk("borrow_one_cycle", int'(bw[0]), 0);

    ld[0] = 1'b1; lv[0] = 4'd7; tick(); ld[0] = 1'b0;
    chk("pre_reset_cnt", int'(cnt[0]), 7);
    add[0] = 1'b1; tick();
    rst = 1'b1; ld[0] = 1'b1; lv[0] = 4'd3; add[0] = 1'b0; tick();
    rst = 1'b0; ld[0] = 1'b0;
    chk("mid_reset_cnt", int'(cnt[0]), 0);

    ld[2] = 1'b1; lv[2] = 4'd7; tick(); ld[2] = 1'b0;
    chk("full_mod_top", int'(cnt[2]), 7);
    add[2] = 1'b0; tick();
    add[2] = 1'b1; tick();
    chk("full_mod_wrap", int'(cnt[2]), 0);
    chk("full_mod_carry", int'(cy[2]), 1);

    for (int k = 0; k < 25; k++) begin
      add[3] = 1'b1; tick(); add[3] = 1'b0; tick();
    end
    tick();
    chk("cascade_units", int'(cnt[3]), 5);
    chk("cascade_tens", int'(cnt[4]), 2);

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        add[i] = 1'($urandom_range(0, 1));
        sub[i] = 1'($urandom_range(0, 1));
        ld[i]  = ($urandom_range(0, 15) == 0);
        lv[i]  = 4'($urandom_range(0, (i == 2) ? 7 : 15));
      end
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld[i] = 1'b0;
    end
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
